// File: rtl/cpu_ctrl_pkg.sv
// Shared types and field codes for the parametrised bitty control unit.
// Only the top's optional timeout path (CPU_CTRL_LS_TIMEOUT_EN) uses cpu_ls_watchdog.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_WB
    } state_e;

    localparam logic [1:0] FMT_ALU = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR  = 2'b10;
    localparam logic [1:0] FMT_LS  = 2'b11;

    localparam logic [1:0] EN_LS_LOAD  = 2'b01;
    localparam logic [1:0] EN_LS_STORE = 2'b10;

    function automatic int ridx_width(input int num_regs);
        return $clog2(num_regs);
    endfunction

    function automatic int imm_width(input int inst_w, input int num_regs);
        return inst_w - 5 - $clog2(num_regs);
    endfunction

endpackage

// File: rtl/cpu_ls_watchdog.sv
// Load/store wait watchdog: counts MEM_WAIT cycles and flags the last permitted one.
// Instantiated by cpu_ctrl_param only when CPU_CTRL_LS_TIMEOUT_EN is defined.
module cpu_ls_watchdog #(
    parameter int LS_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(LS_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside MEM_WAIT, so every entry starts a fresh count.
    always_comb cnt_d = active_i ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout_o = active_i && (cnt_q == CNT_W'(LS_TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl_param.sv
// Multi-cycle control unit for the bitty datapath (IDLE/EXEC/MEM_WAIT/WB).
// Define CPU_CTRL_LS_TIMEOUT_EN to bound MEM_WAIT by LS_TIMEOUT cycles and raise ls_err.
module cpu_ctrl_param
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int INST_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LS_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [INST_W-1:0]        instruction,
    input  logic                     ls_done,
    input  logic                     flag_z,
    output logic [$clog2(NUM_REGS):0] mux_sel,
    output logic [2:0]               alu_sel,
    output logic                     sel_reg_c,
    output logic                     en_s,
    output logic                     en_c,
    output logic [1:0]               en_ls,
    output logic [NUM_REGS-1:0]      en,
    output logic                     en_inst,
    output logic [DATA_W-1:0]        immediate,
    output logic                     br_take,
    output logic [DATA_W-1:0]        br_offset,
    output logic                     done,
    output logic                     busy,
    output logic                     ls_err
);

    localparam int RIDX_W = ridx_width(NUM_REGS);
    localparam int IMM_W  = imm_width(INST_W, NUM_REGS);
    localparam logic [RIDX_W:0] MUX_IMM  = (RIDX_W + 1)'(NUM_REGS);
    localparam logic [RIDX_W:0] MUX_NONE = (RIDX_W + 1)'(NUM_REGS + 1);

    state_e             state_q, state_d;
    logic [INST_W-1:0]  ir_q, ir_d;
    logic               ls_timeout, to_q;

    logic [1:0]         in_fmt, ir_fmt;
    logic [RIDX_W-1:0]  in_dst, ir_dst, ir_src;
    logic [2:0]         ir_op;
    logic [IMM_W-1:0]   ir_imm;

    assign in_fmt = instruction[1:0];
    assign in_dst = instruction[INST_W-1 -: RIDX_W];
    assign ir_fmt = ir_q[1:0];
    assign ir_op  = ir_q[4:2];
    assign ir_imm = ir_q[INST_W-1-RIDX_W:5];
    assign ir_src = ir_q[INST_W-1-RIDX_W -: RIDX_W];
    assign ir_dst = ir_q[INST_W-1 -: RIDX_W];

    assign immediate = {{(DATA_W - IMM_W){1'b0}}, ir_imm};
    assign br_offset = {{(DATA_W - IMM_W){ir_imm[IMM_W-1]}}, ir_imm};
    assign busy      = (state_q != ST_IDLE);

`ifdef CPU_CTRL_LS_TIMEOUT_EN
    logic to_d;

    cpu_ls_watchdog #(
        .LS_TIMEOUT(LS_TIMEOUT)
    ) u_ls_watchdog (
        .clk      (clk),
        .reset    (reset),
        .active_i (state_q == ST_MEM_WAIT),
        .timeout_o(ls_timeout)
    );

    // A simultaneous ls_done completes the access normally, so it masks the timeout.
    assign to_d = (state_q == ST_MEM_WAIT) && ls_timeout && !ls_done;

    always_ff @(posedge clk) begin
        if (!reset) to_q <= 1'b0;
        else        to_q <= to_d;
    end
`else
    assign ls_timeout = 1'b0;
    assign to_q       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    ir_d    = instruction;
                    state_d = (in_fmt == FMT_BR) ? ST_WB : ST_EXEC;
                end
            end
            ST_EXEC:     state_d = (ir_fmt == FMT_LS) ? ST_MEM_WAIT : ST_WB;
            ST_MEM_WAIT: if (ls_done || ls_timeout) state_d = ST_WB;
            ST_WB:       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes are gated by reset so a cycle with reset low never performs a partial writeback.
    always_comb begin
        mux_sel   = MUX_NONE;
        alu_sel   = '0;
        sel_reg_c = 1'b0;
        en_s      = 1'b0;
        en_c      = 1'b0;
        en_ls     = '0;
        en        = '0;
        en_inst   = 1'b1;
        br_take   = 1'b0;
        done      = 1'b0;
        ls_err    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (run && in_fmt != FMT_BR) begin
                        en_s    = 1'b1;
                        mux_sel = {1'b0, in_dst};
                    end
                end
                ST_EXEC: begin
                    en_inst = 1'b0;
                    alu_sel = ir_op;
                    case (ir_fmt)
                        FMT_ALU: begin
                            mux_sel = {1'b0, ir_src};
                            en_c    = 1'b1;
                        end
                        FMT_IMM: begin
                            mux_sel = MUX_IMM;
                            en_c    = 1'b1;
                        end
                        FMT_LS: begin
                            mux_sel = {1'b0, ir_src};
                            en_ls   = ir_op[0] ? EN_LS_STORE : EN_LS_LOAD;
                        end
                        default: ;
                    endcase
                end
                ST_MEM_WAIT: begin
                    en_inst   = 1'b0;
                    sel_reg_c = 1'b1;
                    en_c      = ls_done;
                end
                ST_WB: begin
                    done   = 1'b1;
                    ls_err = to_q;
                    if (ir_fmt == FMT_BR)
                        br_take = !ir_op[0] || flag_z;
                    else if (!to_q && (ir_fmt != FMT_LS || !ir_op[0]))
                        en[ir_dst] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_param.sv
// Directed bench for cpu_ctrl_param at default parameters; timeout scenario needs CPU_CTRL_LS_TIMEOUT_EN.
module tb_cpu_ctrl_param;

    logic        clk = 1'b0;
    logic        reset, run, ls_done, flag_z;
    logic [15:0] instruction;
    logic [3:0]  mux_sel;
    logic [2:0]  alu_sel;
    logic        sel_reg_c, en_s, en_c, en_inst, br_take, done, busy, ls_err;
    logic [1:0]  en_ls;
    logic [7:0]  en;
    logic [15:0] immediate, br_offset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_ctrl_param #(
        .NUM_REGS  (8),
        .INST_W    (16),
        .DATA_W    (16),
        .LS_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instruction(instruction),
        .ls_done    (ls_done),
        .flag_z     (flag_z),
        .mux_sel    (mux_sel),
        .alu_sel    (alu_sel),
        .sel_reg_c  (sel_reg_c),
        .en_s       (en_s),
        .en_c       (en_c),
        .en_ls      (en_ls),
        .en         (en),
        .en_inst    (en_inst),
        .immediate  (immediate),
        .br_take    (br_take),
        .br_offset  (br_offset),
        .done       (done),
        .busy       (busy),
        .ls_err     (ls_err)
    );

    function automatic logic [15:0] mk(input logic [2:0] dst, input logic [7:0] imm,
                                       input logic [2:0] op, input logic [1:0] fmt);
        return {dst, imm, op, fmt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; ls_done = 1'b0; flag_z = 1'b0; instruction = '0;
        tick(); tick();
        #1;
        checks++; if ({busy, done, en_c, en_s} !== 4'b0000) begin $display("FAIL reset_strobes got %b want 0000", {busy, done, en_c, en_s}); errors++; end
        checks++; if (en !== 8'h00) begin $display("FAIL reset_en got %h want 00", en); errors++; end
        checks++; if ({en_inst, mux_sel} !== 5'b1_1001) begin $display("FAIL reset_inst_mux got %b want 11001", {en_inst, mux_sel}); errors++; end
        checks++; if ({immediate, br_offset} !== 32'h0) begin $display("FAIL reset_ir got %h want 0", {immediate, br_offset}); errors++; end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        instruction = mk(3'd3, {3'd5, 5'd0}, 3'b010, 2'b00); run = 1'b1;
        #1;
        checks++; if ({busy, en_s, mux_sel} !== 6'b0_1_0011) begin $display("FAIL alu_idle got %b want 010011", {busy, en_s, mux_sel}); errors++; end
        tick();
        run = 1'b0; instruction = mk(3'd7, 8'hFF, 3'b111, 2'b11);
        #1;
        checks++; if (mux_sel !== 4'd5) begin $display("FAIL alu_exec_mux got %0d want 5", mux_sel); errors++; end
        checks++; if ({alu_sel, en_c, en_inst, en_ls, en_s} !== 8'b010_1_0_00_0) begin $display("FAIL alu_exec_ctl got %b want 01010000", {alu_sel, en_c, en_inst, en_ls, en_s}); errors++; end
        tick(); #1;
        checks++; if ({en, done, en_inst} !== 10'b0000_1000_1_1) begin $display("FAIL alu_wb got %b want 0000100011", {en, done, en_inst}); errors++; end
        tick(); #1;
        checks++; if ({busy, done} !== 2'b00) begin $display("FAIL alu_idle_after got %b want 00", {busy, done}); errors++; end
    endtask

    task automatic test_imm();
        instruction = mk(3'd6, 8'hA5, 3'b001, 2'b01); run = 1'b1;
        #1;
        checks++; if ({en_s, mux_sel} !== 5'b1_0110) begin $display("FAIL imm_idle got %b want 10110", {en_s, mux_sel}); errors++; end
        tick();
        run = 1'b0;
        #1;
        checks++; if ({mux_sel, en_c, alu_sel} !== 8'b1000_1_001) begin $display("FAIL imm_exec got %b want 10001001", {mux_sel, en_c, alu_sel}); errors++; end
        checks++; if (immediate !== 16'h00A5) begin $display("FAIL imm_value got %h want 00a5", immediate); errors++; end
        tick(); #1;
        checks++; if ({en, done} !== 9'b0100_0000_1) begin $display("FAIL imm_wb got %b want 010000001", {en, done}); errors++; end
        tick();
    endtask

    task automatic test_load();
        instruction = mk(3'd2, {3'd4, 5'd0}, 3'b000, 2'b11); run = 1'b1;
        tick();
        run = 1'b0;
        #1;
        checks++; if ({en_ls, mux_sel, en_c} !== 7'b01_0100_0) begin $display("FAIL load_exec got %b want 0101000", {en_ls, mux_sel, en_c}); errors++; end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({sel_reg_c, en_ls, en_c, en_inst, done} !== 6'b1_00_0_0_0) begin $display("FAIL load_wait%0d got %b want 100000", i, {sel_reg_c, en_ls, en_c, en_inst, done}); errors++; end
            tick();
        end
        ls_done = 1'b1;
        #1;
        checks++; if ({sel_reg_c, en_c} !== 2'b11) begin $display("FAIL load_done got %b want 11", {sel_reg_c, en_c}); errors++; end
        tick();
        ls_done = 1'b0;
        #1;
        checks++; if ({en, done, sel_reg_c} !== 10'b0000_0100_1_0) begin $display("FAIL load_wb got %b want 0000010010", {en, done, sel_reg_c}); errors++; end
        tick();
    endtask

    task automatic test_store();
        instruction = mk(3'd1, 8'h00, 3'b001, 2'b11); run = 1'b1;
        tick();
        run = 1'b0;
        #1;
        checks++; if (en_ls !== 2'b10) begin $display("FAIL store_exec got %b want 10", en_ls); errors++; end
        tick();
        ls_done = 1'b1;
        #1;
        checks++; if ({en_c, en_ls} !== 3'b1_00) begin $display("FAIL store_done got %b want 100", {en_c, en_ls}); errors++; end
        tick();
        ls_done = 1'b0;
        #1;
        checks++; if ({en, done} !== 9'b0000_0000_1) begin $display("FAIL store_wb got %b want 000000001", {en, done}); errors++; end
        tick();
    endtask

    task automatic test_branch();
        logic [2:0]  ops  [3] = '{3'b001, 3'b001, 3'b000};
        logic        zs   [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0]  imms [3] = '{8'hFE, 8'hFE, 8'h05};
        logic        takes[3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] offs [3] = '{16'hFFFE, 16'hFFFE, 16'h0005};
        for (int i = 0; i < 3; i++) begin
            instruction = mk(3'd0, imms[i], ops[i], 2'b10); flag_z = zs[i]; run = 1'b1;
            #1;
            checks++; if ({en_s, mux_sel} !== 5'b0_1001) begin $display("FAIL br%0d_idle got %b want 01001", i, {en_s, mux_sel}); errors++; end
            tick();
            run = 1'b0;
            #1;
            checks++; if ({busy, done, br_take, en} !== {2'b11, takes[i], 8'h00}) begin $display("FAIL br%0d_wb got %b want %b", i, {busy, done, br_take, en}, {2'b11, takes[i], 8'h00}); errors++; end
            checks++; if (br_offset !== offs[i]) begin $display("FAIL br%0d_offset got %h want %h", i, br_offset, offs[i]); errors++; end
            tick(); #1;
            checks++; if ({busy, br_take} !== 2'b00) begin $display("FAIL br%0d_after got %b want 00", i, {busy, br_take}); errors++; end
        end
        flag_z = 1'b0;
    endtask

    task automatic test_back_to_back();
        instruction = mk(3'd3, 8'h00, 3'b000, 2'b00); run = 1'b1;
        #1;
        checks++; if (en_s !== 1'b1) begin $display("FAIL b2b_first_en_s got %b want 1", en_s); errors++; end
        tick();
        instruction = mk(3'd5, 8'h00, 3'b000, 2'b01);
        #1;
        checks++; if ({busy, en_s, mux_sel} !== 6'b1_0_0000) begin $display("FAIL b2b_exec_ignores_run got %b want 100000", {busy, en_s, mux_sel}); errors++; end
        tick(); #1;
        checks++; if ({en, done} !== 9'b0000_1000_1) begin $display("FAIL b2b_wb1 got %b want 000010001", {en, done}); errors++; end
        tick(); #1;
        checks++; if ({busy, en_s, mux_sel} !== 6'b0_1_0101) begin $display("FAIL b2b_restart got %b want 010101", {busy, en_s, mux_sel}); errors++; end
        tick();
        run = 1'b0;
        #1;
        checks++; if (mux_sel !== 4'd8) begin $display("FAIL b2b_exec2_mux got %0d want 8", mux_sel); errors++; end
        tick(); #1;
        checks++; if ({en, done} !== 9'b0010_0000_1) begin $display("FAIL b2b_wb2 got %b want 001000001", {en, done}); errors++; end
        tick();
    endtask

    task automatic test_reset_mid();
        instruction = mk(3'd4, 8'h00, 3'b000, 2'b11); run = 1'b1;
        tick();
        run = 1'b0; reset = 1'b0;
        #1;
        checks++; if ({en_ls, en_c, en_inst, done, en} !== {2'b00, 1'b0, 1'b1, 1'b0, 8'h00}) begin $display("FAIL rstmid_exec got %b want 00010", {en_ls, en_c, en_inst, done}); errors++; end
        tick(); #1;
        checks++; if ({busy, done, en_ls, en} !== {1'b0, 1'b0, 2'b00, 8'h00}) begin $display("FAIL rstmid_idle got %b want 0000", {busy, done, en_ls}); errors++; end
        tick();
        reset = 1'b1;
        #1;
        checks++; if ({busy, done, en_inst} !== 3'b001) begin $display("FAIL rstmid_release got %b want 001", {busy, done, en_inst}); errors++; end
        tick(); #1;
        checks++; if ({busy, done, en} !== {2'b00, 8'h00}) begin $display("FAIL rstmid_nowb got %b want 0000000000", {busy, done, en}); errors++; end
    endtask

    task automatic test_ls_wait();
        instruction = mk(3'd7, {3'd1, 5'd0}, 3'b000, 2'b11); run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        for (int k = 1; k <= 15; k++) begin
            #1;
            checks++; if ({sel_reg_c, ls_err, done} !== 3'b100) begin $display("FAIL lswait_cyc%0d got %b want 100", k, {sel_reg_c, ls_err, done}); errors++; end
            tick();
        end
`ifdef CPU_CTRL_LS_TIMEOUT_EN
        #1;
        checks++; if ({busy, done, ls_err, sel_reg_c, en} !== {4'b1110, 8'h00}) begin $display("FAIL lswait_timeout got %b want 111000000000", {busy, done, ls_err, sel_reg_c, en}); errors++; end
        tick(); #1;
        checks++; if ({busy, ls_err} !== 2'b00) begin $display("FAIL lswait_after got %b want 00", {busy, ls_err}); errors++; end
        // ls_done on the last permitted cycle completes the load normally
        instruction = mk(3'd6, 8'h00, 3'b000, 2'b11); run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        for (int k = 1; k < 15; k++) tick();
        ls_done = 1'b1;
        #1;
        checks++; if (en_c !== 1'b1) begin $display("FAIL lstie_en_c got %b want 1", en_c); errors++; end
        tick();
        ls_done = 1'b0;
        #1;
        checks++; if ({en, done, ls_err} !== {8'h40, 2'b10}) begin $display("FAIL lstie_wb got %b want 0100000010", {en, done, ls_err}); errors++; end
        tick();
`else
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({busy, sel_reg_c, ls_err} !== 3'b110) begin $display("FAIL lswait_hold%0d got %b want 110", k, {busy, sel_reg_c, ls_err}); errors++; end
            tick();
        end
        ls_done = 1'b1;
        #1;
        checks++; if (en_c !== 1'b1) begin $display("FAIL lswait_done got %b want 1", en_c); errors++; end
        tick();
        ls_done = 1'b0;
        #1;
        checks++; if ({en, done, ls_err} !== {8'h80, 2'b10}) begin $display("FAIL lswait_wb got %b want 1000000010", {en, done, ls_err}); errors++; end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_load();
        test_store();
        test_branch();
        test_back_to_back();
        test_reset_mid();
        test_ls_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
